// File: rtl/cic_comb_sequencer_if.sv
// Sample/control bundle between the integrator chain, the comb sequencer and the output framer.
// The master drives samples and control; the slave returns comb results and status.
interface cic_comb_sequencer_if #(
    parameter int unsigned W = 19
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         clear;
    logic         clear_ovr;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;
    logic         overrun;

    modport master (
        output in_valid, in_data, clear, clear_ovr,
        input  out_valid, out_data, busy, overrun
    );

    modport slave (
        input  in_valid, in_data, clear, clear_ovr,
        output out_valid, out_data, busy, overrun
    );
endinterface

// File: rtl/cic_comb_sequencer.sv
// Time-multiplexed CIC comb cascade: decimates integrator samples by DECIM, then runs each
// kept sample through STAGES comb stages on one shared subtractor, one stage per clock.
module cic_comb_sequencer #(
    parameter int unsigned W      = 19,
    parameter int unsigned STAGES = 3,
    parameter int unsigned DECIM  = 64
) (
    input logic                 clk,
    input logic                 rst,
    cic_comb_sequencer_if.slave bus
);
    localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned KW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DECIM - 1);
    localparam logic [KW-1:0] KLast = KW'(STAGES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [KW-1:0]            k_q, k_d;
    logic [W-1:0]             x_q, x_d;
    logic [STAGES-1:0][W-1:0] d_q, d_d;
    logic [W-1:0]             out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     capture;
    logic [W-1:0]             diff;

    assign capture = bus.in_valid && (cnt_q == CntLast);
    assign diff    = x_q - d_q[k_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        x_d         = x_q;
        d_d         = d_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (bus.in_valid) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
        end
        if (bus.clear_ovr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    x_d     = bus.in_data;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // d[k] takes the pre-subtraction value: it is this stage's x[n-1] next time.
                x_d      = diff;
                d_d[k_q] = x_q;
                k_d      = k_q + KW'(1);
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (k_q == KLast) begin
                    out_data_d  = diff;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush discards any capture in the same cycle, so it never counts as a drop.
        if (bus.clear) begin
            state_d     = StIdle;
            cnt_d       = '0;
            k_d         = '0;
            x_d         = '0;
            d_d         = '0;
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
            overrun_d   = bus.clear_ovr ? 1'b0 : overrun_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            k_q         <= '0;
            x_q         <= '0;
            d_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            x_q         <= x_d;
            d_q         <= d_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == StRun);
    assign bus.overrun   = overrun_q;
endmodule
